// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// gpio_pkg : shared constants and state encoding for the GPIO serializer
// Rev 1.0
// ============================================================================
package gpio_pkg;

   localparam int c_def_width = 32;
   localparam int c_def_div   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // Counter width helper that never returns zero (DIV = 1 or WIDTH = 1).
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_shift_out_if.sv
`default_nettype none
// ============================================================================
// gpio_shift_out_if : GPIO word in, serial shift-register chain out
// Rev 1.0
// ============================================================================
interface gpio_shift_out_if #(
   parameter int WIDTH = gpio_pkg::c_def_width
);
   logic [WIDTH-1:0] Q_in;
   logic             refresh;
   logic             sclk;
   logic             sdata;
   logic             slatch;
   logic             busy;

   modport master (
      output Q_in, refresh,
      input  sclk, sdata, slatch, busy
   );

   modport slave (
      input  Q_in, refresh,
      output sclk, sdata, slatch, busy
   );
endinterface
`default_nettype wire

// File: rtl/gpio_shift_div.sv
`default_nettype none
// ============================================================================
// gpio_shift_div : half-period counter, one-cycle tick every DIV enabled cycles
// Rev 1.0
// ============================================================================
module gpio_shift_div
   import gpio_pkg::*;
#(
   parameter int DIV = c_def_div
) (
   input  logic clock,
   input  logic reset,
   input  logic i_en,
   output logic o_tick
);
   localparam int               c_cw   = clog2_min1(DIV);
   localparam logic [c_cw-1:0]  c_last = c_cw'(DIV - 1);

   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!i_en || (r_cnt == c_last)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/gpio_shift_out.sv
`default_nettype none
// ============================================================================
// gpio_shift_out : serializes the GPIO output word MSB first to an external
//                  shift-register chain whenever it changes or on refresh
// Rev 1.0
// ============================================================================
module gpio_shift_out
   import gpio_pkg::*;
#(
   parameter int WIDTH = c_def_width,
   parameter int DIV   = c_def_div
) (
   input  logic            clock,
   input  logic            reset,
   gpio_shift_out_if.slave bus
);
   localparam int              c_bw      = clog2_min1(WIDTH);
   localparam logic [c_bw-1:0] c_top_bit = c_bw'(WIDTH - 1);

   state_t           r_state,  w_state;
   logic [WIDTH-1:0] r_shreg,  w_shreg;
   logic [WIDTH-1:0] r_shadow, w_shadow;
   logic [WIDTH-1:0] w_shl;
   logic [c_bw-1:0]  r_bit,    w_bit;
   logic             r_sclk,   w_sclk;
   logic             r_sdata,  w_sdata;
   logic             r_slatch, w_slatch;
   logic             r_busy,   w_busy;
   logic             w_start;
   logic             w_tick;
   logic             w_div_en;

   assign w_div_en = (r_state != ST_IDLE);

   gpio_shift_div #(
      .DIV (DIV)
   ) u_div (
      .clock  (clock),
      .reset  (reset),
      .i_en   (w_div_en),
      .o_tick (w_tick)
   );

   // Refresh and a changed word collapse into one start request.
   assign w_start = (bus.Q_in != r_shadow) || bus.refresh;
   assign w_shl   = r_shreg << 1;

   always_comb begin
      w_state  = r_state;
      w_shreg  = r_shreg;
      w_shadow = r_shadow;
      w_bit    = r_bit;
      w_sclk   = r_sclk;
      w_sdata  = r_sdata;
      w_slatch = r_slatch;
      w_busy   = r_busy;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state  = ST_SHIFT;
               w_shreg  = bus.Q_in;
               w_shadow = bus.Q_in;
               w_sdata  = bus.Q_in[WIDTH-1];
               w_sclk   = 1'b0;
               w_bit    = c_top_bit;
               w_busy   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else if (r_bit == '0) begin
                  w_sclk   = 1'b0;
                  w_slatch = 1'b1;
                  w_state  = ST_LATCH;
               end else begin
                  // Data only moves on the falling edge that starts a bit.
                  w_sclk  = 1'b0;
                  w_bit   = r_bit - 1'b1;
                  w_shreg = w_shl;
                  w_sdata = w_shl[WIDTH-1];
               end
            end
         end
         ST_LATCH: begin
            if (w_tick) begin
               w_slatch = 1'b0;
               w_busy   = 1'b0;
               w_state  = ST_IDLE;
            end
         end
         default: begin
            w_state  = ST_IDLE;
            w_sclk   = 1'b0;
            w_slatch = 1'b0;
            w_busy   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_shadow <= '0;
         r_bit    <= '0;
         r_sclk   <= 1'b0;
         r_sdata  <= 1'b0;
         r_slatch <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_shreg  <= w_shreg;
         r_shadow <= w_shadow;
         r_bit    <= w_bit;
         r_sclk   <= w_sclk;
         r_sdata  <= w_sdata;
         r_slatch <= w_slatch;
         r_busy   <= w_busy;
      end
   end

   assign bus.sclk   = r_sclk;
   assign bus.sdata  = r_sdata;
   assign bus.slatch = r_slatch;
   assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpio_shift_out.sv
`default_nettype none
// ============================================================================
// tb_gpio_shift_out : randomized bench for gpio_shift_out (32/4 and 8/1 builds)
// Rev 1.0
// ============================================================================
module tb_gpio_shift_out;
   localparam int WA = 32;
   localparam int DA = 4;
   localparam int WB = 8;
   localparam int DB = 1;
   localparam int c_busy_a = 2 * DA * WA + DA;
   localparam int c_busy_b = 2 * DB * WB + DB;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   gpio_shift_out_if #(.WIDTH(WA)) a ();
   gpio_shift_out_if #(.WIDTH(WB)) b ();

   gpio_shift_out #(.WIDTH(WA), .DIV(DA)) dut_a (.clock(clock), .reset(reset), .bus(a.slave));
   gpio_shift_out #(.WIDTH(WB), .DIV(DB)) dut_b (.clock(clock), .reset(reset), .bus(b.slave));

   // One observed transfer of the 32-bit build, as seen on the pins.
   typedef struct {
      logic [31:0] word;
      int rises;
      int busy_cyc;
      int latch_cyc;
      int latch_at;
      int bad_edges;
      int gap;
   } rec_t;

   rec_t        recs[$];
   logic [31:0] m_word;
   int m_rises, m_busy, m_latch, m_latch_at, m_bad, m_gap, m_gap_start, m_idle_bad;
   logic m_sclk_p, m_sdata_p, m_slatch_p, m_busy_p;

   initial m_idle_bad = 0;

   always @(negedge clock) begin
      if (!reset) begin
         m_word <= '0; m_rises <= 0; m_busy <= 0; m_latch <= 0; m_latch_at <= -1;
         m_bad <= 0; m_gap <= 0; m_gap_start <= 0;
         m_sclk_p <= 1'b0; m_sdata_p <= 1'b0; m_slatch_p <= 1'b0; m_busy_p <= 1'b0;
      end else begin
         m_sclk_p <= a.sclk; m_sdata_p <= a.sdata; m_slatch_p <= a.slatch; m_busy_p <= a.busy;
         if (!a.busy && (a.sclk || a.slatch)) m_idle_bad <= m_idle_bad + 1;
         if (a.busy && !m_busy_p) begin
            m_gap_start <= m_gap; m_gap <= 0;
            m_busy <= 1; m_word <= '0; m_rises <= 0; m_latch <= 0; m_latch_at <= -1; m_bad <= 0;
         end else if (a.busy) begin
            m_busy <= m_busy + 1;
            if (a.sclk && !m_sclk_p) begin
               m_word  <= {m_word[30:0], a.sdata};
               m_rises <= m_rises + 1;
            end
            m_bad <= m_bad + int'(a.sclk && m_sclk_p && (a.sdata !== m_sdata_p))
                           + int'(a.slatch && a.sclk);
            if (a.slatch) begin
               m_latch <= m_latch + 1;
               if (!m_slatch_p) m_latch_at <= m_rises;
            end
         end else begin
            m_gap <= m_gap + 1;
            if (m_busy_p)
               recs.push_back('{word: m_word, rises: m_rises, busy_cyc: m_busy, latch_cyc: m_latch,
                                latch_at: m_latch_at, bad_edges: m_bad, gap: m_gap_start});
         end
      end
   end

   task automatic wait_recs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && recs.size() < n; i++) @(posedge clock);
      if (recs.size() >= n) ok = 1'b1;
   endtask

   task automatic wait_busy_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clock);
         if (a.busy) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int v;
      reset = 1'b0; a.Q_in = '0; a.refresh = 1'b0; b.Q_in = '0; b.refresh = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if ({a.busy, a.sclk, a.sdata, a.slatch} !== 4'b0) begin
         bad++; $display("FAIL reset_a: got %b want 0000", {a.busy, a.sclk, a.sdata, a.slatch});
      end
      total++;
      if ({b.busy, b.sclk, b.sdata, b.slatch} !== 4'b0) begin
         bad++; $display("FAIL reset_b: got %b want 0000", {b.busy, b.sclk, b.sdata, b.slatch});
      end
      reset = 1'b1;
      v = 0;
      repeat (50) begin
         @(negedge clock);
         if (a.busy || a.sclk || a.slatch || b.busy) v++;
      end
      total++;
      if (v !== 0) begin
         bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", v);
      end
      total++;
      if (recs.size() !== 0) begin
         bad++; $display("FAIL idle_no_xfer: got %0d transfers want 0", recs.size());
      end
   endtask

   task automatic test_single();
      logic [31:0] w;
      rec_t r;
      bit ok;
      int n;
      for (int t = 0; t < 4; t++) begin
         w = (t == 0) ? 32'h0000_0ADF : $urandom;
         if (w == a.Q_in || w == 32'h0000_ABCD) w = w ^ 32'h8000_0001;
         n = recs.size();
         @(posedge clock); #1 a.Q_in = w;
         wait_recs(n + 1, 400, ok);
         total++;
         if (!ok) begin
            bad++; $display("FAIL single_timeout: got no transfer want word %h", w);
         end else begin
            r = recs[n];
            total++;
            if (r.word !== w) begin bad++; $display("FAIL single_word: got %h want %h", r.word, w); end
            total++;
            if (r.busy_cyc !== c_busy_a) begin bad++; $display("FAIL single_busy: got %0d want %0d", r.busy_cyc, c_busy_a); end
            total++;
            if (r.rises !== WA) begin bad++; $display("FAIL single_rises: got %0d want %0d", r.rises, WA); end
            total++;
            if (r.latch_cyc !== DA || r.latch_at !== WA) begin
               bad++; $display("FAIL single_latch: got len %0d after %0d rises want %0d after %0d", r.latch_cyc, r.latch_at, DA, WA);
            end
            total++;
            if (r.bad_edges !== 0) begin bad++; $display("FAIL single_edges: got %0d bad edges want 0", r.bad_edges); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] mid;
      rec_t r0, r1;
      bit ok;
      int n;
      n = recs.size();
      mid = $urandom | 32'h0100_0000;
      @(posedge clock); #1 a.Q_in = 32'h0000_ABCD;
      wait_busy_a(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_start: got busy 0 want 1"); end
      repeat (50) @(posedge clock);
      #1 a.Q_in = mid;
      repeat (50) @(posedge clock);
      #1 a.Q_in = 32'h0000_1234;
      wait_recs(n + 2, 800, ok);
      repeat (300) @(posedge clock);
      total++;
      if (recs.size() !== n + 2) begin
         bad++; $display("FAIL b2b_count: got %0d transfers want %0d", recs.size() - n, 2);
      end else begin
         r0 = recs[n]; r1 = recs[n + 1];
         total++;
         if (r0.word !== 32'h0000_ABCD) begin bad++; $display("FAIL b2b_first: got %h want 0000abcd", r0.word); end
         total++;
         if (r1.word !== 32'h0000_1234) begin bad++; $display("FAIL b2b_second: got %h want 00001234", r1.word); end
         total++;
         if (r1.gap !== 1) begin bad++; $display("FAIL b2b_gap: got %0d idle cycles want 1", r1.gap); end
         total++;
         if (r1.busy_cyc !== c_busy_a) begin bad++; $display("FAIL b2b_busy: got %0d want %0d", r1.busy_cyc, c_busy_a); end
      end
   endtask

   task automatic test_refresh();
      logic [31:0] w;
      bit ok;
      int n;
      n = recs.size();
      @(posedge clock); #1 a.Q_in = 32'h5;
      wait_recs(n + 1, 400, ok);
      repeat (10) @(posedge clock);
      #1 a.refresh = 1'b1;
      @(posedge clock); #1 a.refresh = 1'b0;
      wait_busy_a(ok);
      @(posedge clock); #1 a.refresh = 1'b1;
      repeat (150) @(posedge clock);
      #1 a.refresh = 1'b0;
      wait_recs(n + 2, 400, ok);
      repeat (300) @(posedge clock);
      total++;
      if (recs.size() !== n + 2) begin
         bad++; $display("FAIL refresh_count: got %0d transfers want 2", recs.size() - n);
      end else begin
         total++;
         if (recs[n + 1].word !== 32'h5 || recs[n + 1].busy_cyc !== c_busy_a) begin
            bad++; $display("FAIL refresh_word: got %h/%0d want 00000005/%0d", recs[n + 1].word, recs[n + 1].busy_cyc, c_busy_a);
         end
      end
      n = recs.size();
      w = $urandom | 32'h10;
      @(posedge clock); #1 a.Q_in = w; a.refresh = 1'b1;
      @(posedge clock); #1 a.refresh = 1'b0;
      wait_recs(n + 1, 400, ok);
      repeat (300) @(posedge clock);
      total++;
      if (recs.size() !== n + 1 || recs[n].word !== w) begin
         bad++; $display("FAIL refresh_and_change: got %0d transfers want 1 of %h", recs.size() - n, w);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      rec_t r;
      bit ok;
      int n;
      w = $urandom | 32'h0000_0400;
      if (w == a.Q_in) w = w ^ 32'h8000_0000;
      @(posedge clock); #1 a.Q_in = w;
      wait_busy_a(ok);
      repeat (170) @(posedge clock);
      #3;
      total++;
      if (a.busy !== 1'b1 || a.sdata !== 1'b1) begin
         bad++; $display("FAIL midrst_pre: got busy %b sdata %b want 1 1", a.busy, a.sdata);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({a.busy, a.sclk, a.sdata, a.slatch} !== 4'b0) begin
         bad++; $display("FAIL midrst_async: got %b want 0000", {a.busy, a.sclk, a.sdata, a.slatch});
      end
      n = recs.size();
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      wait_recs(n + 1, 400, ok);
      repeat (20) @(posedge clock);
      total++;
      if (recs.size() !== n + 1) begin
         bad++; $display("FAIL midrst_count: got %0d transfers want 1", recs.size() - n);
      end else begin
         r = recs[n];
         total++;
         if (r.word !== w || r.busy_cyc !== c_busy_a || r.latch_cyc !== DA) begin
            bad++; $display("FAIL midrst_restart: got %h/%0d/%0d want %h/%0d/%0d", r.word, r.busy_cyc, r.latch_cyc, w, c_busy_a, DA);
         end
      end
   endtask

   task automatic test_div1();
      logic [7:0] w, got;
      int k, rises, perr;
      logic prev;
      for (int t = 0; t < 3; t++) begin
         w = (t == 0) ? 8'hA5 : 8'($urandom);
         if (w == b.Q_in) w = ~w;
         @(posedge clock); #1 b.Q_in = w;
         k = 0; rises = 0; perr = 0; got = '0; prev = 1'b0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (b.busy) begin
               if (k < 2 * DB * WB) begin
                  if (b.sclk !== k[0] || b.slatch !== 1'b0) perr++;
               end else if (b.sclk !== 1'b0 || b.slatch !== 1'b1) perr++;
               if (b.sclk && !prev) begin got = {got[6:0], b.sdata}; rises++; end
               k++;
            end else if (k > 0) break;
            prev = b.sclk;
         end
         total++;
         if (k !== c_busy_b) begin bad++; $display("FAIL div1_busy: got %0d want %0d", k, c_busy_b); end
         total++;
         if (got !== w || rises !== WB) begin
            bad++; $display("FAIL div1_byte: got %h in %0d rises want %h in %0d", got, rises, w, WB);
         end
         total++;
         if (perr !== 0) begin bad++; $display("FAIL div1_pattern: got %0d bad cycles want 0", perr); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_refresh();
      test_reset_mid();
      test_div1();
      total++;
      if (m_idle_bad !== 0) begin
         bad++; $display("FAIL idle_outputs: got %0d cycles with sclk/slatch while idle want 0", m_idle_bad);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
